// File: rtl/sprite_plot_scheduler.sv
// N-channel sprite draw/erase arbiter with registered VGA plot mux.
// Optional watchdog: define SPRITE_SCHED_TIMEOUT_EN.
module sprite_plot_scheduler #(
   parameter int NUM_CH  = 5,
   parameter int X_W     = 9,
   parameter int Y_W     = 8,
   parameter int COL_W   = 3,
   parameter int RR_MODE = 0,
   parameter int TIMEOUT = 4096
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_CH-1:0]         req,
   input  logic [NUM_CH-1:0]         fin,
   input  logic [NUM_CH*X_W-1:0]     ch_x,
   input  logic [NUM_CH*Y_W-1:0]     ch_y,
   input  logic [NUM_CH*COL_W-1:0]   ch_colour,
   output logic [NUM_CH-1:0]         grant,
   output logic [X_W-1:0]            x,
   output logic [Y_W-1:0]            y,
   output logic [COL_W-1:0]          colour,
   output logic                      plot,
   output logic                      busy,
   output logic [$clog2(NUM_CH)-1:0] cur_ch,
   output logic                      timeout_err
);

   localparam int CH_W = $clog2(NUM_CH);

   typedef enum logic {
      IDLE,
      SERVE
   } state_t;

   state_t              state_q;
   logic [NUM_CH-1:0]   pending_q, pending_d;
   logic [NUM_CH-1:0]   grant_q;
   logic [CH_W-1:0]     cur_q, last_q;
   logic [X_W-1:0]      x_q;
   logic [Y_W-1:0]      y_q;
   logic [COL_W-1:0]    col_q;
   logic                plot_q, busy_q;

   logic                fin_sel, to_hit, done;
   logic [X_W-1:0]      sel_x;
   logic [Y_W-1:0]      sel_y;
   logic [COL_W-1:0]    sel_c;
   logic [CH_W-1:0]     win;
   logic [NUM_CH-1:0]   win_oh;
   logic                found;
   int                  start;

   always_comb begin
      fin_sel = 1'b0;
      sel_x   = '0;
      sel_y   = '0;
      sel_c   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cur_q == CH_W'(i)) begin
            fin_sel = fin[i];
            sel_x   = ch_x[i*X_W +: X_W];
            sel_y   = ch_y[i*Y_W +: Y_W];
            sel_c   = ch_colour[i*COL_W +: COL_W];
         end
      end
   end

   // Two-pass search: indices at/after the start point first, then wrap.
   always_comb begin
      start  = 0;
      found  = 1'b0;
      win    = '0;
      win_oh = '0;
      if (RR_MODE != 0) begin
         start = int'(last_q) + 1;
         if (start >= NUM_CH) start = 0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (!found && pending_q[i] && i >= start) begin
            found = 1'b1;
            win   = CH_W'(i);
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (!found && pending_q[i]) begin
            found = 1'b1;
            win   = CH_W'(i);
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
         win_oh[i] = (win == CH_W'(i));
      end
   end

   assign done = (state_q == SERVE) && (fin_sel || to_hit);

   // New requests win over the completion clear.
   always_comb begin
      pending_d = pending_q;
      if (done) pending_d = pending_d & ~grant_q;
      pending_d = pending_d | req;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         pending_q <= '0;
         grant_q   <= '0;
         cur_q     <= '0;
         last_q    <= CH_W'(NUM_CH - 1);
         x_q       <= '0;
         y_q       <= '0;
         col_q     <= '0;
         plot_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         pending_q <= pending_d;
         plot_q    <= (state_q == SERVE);
         if (state_q == SERVE) begin
            x_q   <= sel_x;
            y_q   <= sel_y;
            col_q <= sel_c;
         end
         unique case (state_q)
            IDLE: begin
               if (|pending_q) begin
                  state_q <= SERVE;
                  cur_q   <= win;
                  grant_q <= win_oh;
                  busy_q  <= 1'b1;
               end
            end
            SERVE: begin
               if (done) begin
                  state_q <= IDLE;
                  grant_q <= '0;
                  busy_q  <= 1'b0;
                  last_q  <= cur_q;
               end
            end
         endcase
      end
   end

`ifdef SPRITE_SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT) + 1;

   logic [TO_W-1:0] to_cnt_q;
   logic            to_err_q;

   assign to_hit = (state_q == SERVE) && !fin_sel &&
                   (to_cnt_q == TO_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         to_cnt_q <= '0;
         to_err_q <= 1'b0;
      end else begin
         to_cnt_q <= (state_q == SERVE) ? to_cnt_q + TO_W'(1) : '0;
         if (to_hit) to_err_q <= 1'b1;
      end
   end

   assign timeout_err = to_err_q;
`else
   logic unused_to;

   assign unused_to   = (TIMEOUT != 0);
   assign to_hit      = 1'b0;
   assign timeout_err = 1'b0;
`endif

   assign grant  = grant_q;
   assign x      = x_q;
   assign y      = y_q;
   assign colour = col_q;
   assign plot   = plot_q;
   assign busy   = busy_q;
   assign cur_ch = cur_q;

endmodule

// File: tb/tb_sprite_plot_scheduler.sv
// Scoreboard bench for sprite_plot_scheduler (fixed-priority and
// round-robin instances sharing pixel buses).
module tb_sprite_plot_scheduler;

   localparam int N = 5;

   typedef struct packed {
      logic [8:0] x;
      logic [7:0] y;
      logic [2:0] c;
   } px_t;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req, fin, req1, fin1;
   logic [N*9-1:0] ch_x;
   logic [N*8-1:0] ch_y;
   logic [N*3-1:0] ch_c;

   logic [N-1:0]   grant, grant1;
   logic [8:0]     x, x1;
   logic [7:0]     y, y1;
   logic [2:0]     colour, colour1;
   logic           plot, plot1, busy, busy1, terr, terr1;
   logic [2:0]     cur_ch, cur_ch1;

   int  n_chk = 0;
   int  n_pass = 0;
   int  cyc = 0;
   px_t exp_q[$];
   px_t last_px = '0;

   sprite_plot_scheduler #(
      .NUM_CH(N), .X_W(9), .Y_W(8), .COL_W(3),
      .RR_MODE(0), .TIMEOUT(16)
   ) u0 (
      .clk(clk), .reset(reset), .req(req), .fin(fin),
      .ch_x(ch_x), .ch_y(ch_y), .ch_colour(ch_c),
      .grant(grant), .x(x), .y(y), .colour(colour),
      .plot(plot), .busy(busy), .cur_ch(cur_ch),
      .timeout_err(terr)
   );

   sprite_plot_scheduler #(
      .NUM_CH(N), .X_W(9), .Y_W(8), .COL_W(3),
      .RR_MODE(1), .TIMEOUT(16)
   ) u1 (
      .clk(clk), .reset(reset), .req(req1), .fin(fin1),
      .ch_x(ch_x), .ch_y(ch_y), .ch_colour(ch_c),
      .grant(grant1), .x(x1), .y(y1), .colour(colour1),
      .plot(plot1), .busy(busy1), .cur_ch(cur_ch1),
      .timeout_err(terr1)
   );

   always #5 clk = ~clk;

   // Plot monitor: every plotted pixel must match the next expected one.
   always @(negedge clk) begin
      if (plot) begin
         px_t p;
         n_chk++;
         if (exp_q.size() == 0) begin
            $display("FAIL plot_unexpected got x=%0d y=%0d c=%0d expected none",
                     x, y, colour);
         end else begin
            p = exp_q.pop_front();
            last_px = p;
            if ({x, y, colour} !== p)
               $display("FAIL plot_pixel got %h required %h",
                        {x, y, colour}, p);
            else
               n_pass++;
         end
      end
   end

   task automatic step(input int srv, input logic [N-1:0] r,
                       input logic [N-1:0] f);
      px_t p;
      req = r;
      fin = f;
      for (int i = 0; i < N; i++) begin
         ch_x[i*9 +: 9] = 9'((cyc * 3 + i * 50) % 512);
         ch_y[i*8 +: 8] = 8'((cyc * 5 + i * 17) % 256);
         ch_c[i*3 +: 3] = 3'((cyc + i) % 8);
      end
      if (srv >= 0) begin
         p.x = ch_x[srv*9 +: 9];
         p.y = ch_y[srv*8 +: 8];
         p.c = ch_c[srv*3 +: 3];
         exp_q.push_back(p);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req = '0; fin = '0; req1 = '0; fin1 = '0;
      ch_x = '0; ch_y = '0; ch_c = '0;
      #23;
      n_chk++;
      if ({grant, plot, busy, cur_ch, x, y, colour, terr} !== '0)
         $display("FAIL reset_state got %h required 0",
                  {grant, plot, busy, cur_ch, x, y, colour, terr});
      else n_pass++;
      @(posedge clk);
      #1;
      reset = 1'b1;
      step(-1, '0, '0);
      n_chk++;
      if (grant !== 5'b0) $display("FAIL reset_idle got %b required 0", grant);
      else n_pass++;
   endtask

   task automatic test_single();
      step(-1, 5'b00100, '0);
      n_chk++;
      if (grant !== 5'b0) $display("FAIL single_e0 got %b required 0", grant);
      else n_pass++;
      step(-1, '0, '0);
      n_chk++;
      if ({grant, busy, cur_ch} !== {5'b00100, 1'b1, 3'd2})
         $display("FAIL single_grant got %b/%b/%0d required 00100/1/2",
                  grant, busy, cur_ch);
      else n_pass++;
      step(2, '0, '0);
      n_chk++;
      if (plot !== 1'b1) $display("FAIL single_plot got %b required 1", plot);
      else n_pass++;
      for (int i = 0; i < 5; i++) step(2, '0, '0);
      step(2, '0, 5'b00100);
      n_chk++;
      if ({grant, plot, busy} !== {5'b0, 1'b1, 1'b0})
         $display("FAIL single_fin got %b/%b/%b required 00000/1/0",
                  grant, plot, busy);
      else n_pass++;
      step(-1, '0, '0);
      n_chk++;
      if (plot !== 1'b0) $display("FAIL single_plot_off got %b required 0", plot);
      else n_pass++;
      step(-1, '0, '0);
      n_chk++;
      if ({x, y, colour, cur_ch} !== {last_px, 3'd2})
         $display("FAIL single_hold got %h required %h",
                  {x, y, colour, cur_ch}, {last_px, 3'd2});
      else n_pass++;
   endtask

   task automatic test_priority();
      step(-1, 5'b10010, '0);
      step(-1, '0, '0);
      n_chk++;
      if (grant !== 5'b00010) $display("FAIL prio_first got %b required 00010", grant);
      else n_pass++;
      step(1, '0, '0);
      step(1, '0, '0);
      step(1, '0, 5'b10010);
      n_chk++;
      if (grant !== 5'b0) $display("FAIL prio_release got %b required 0", grant);
      else n_pass++;
      step(-1, '0, '0);
      n_chk++;
      if (grant !== 5'b10000) $display("FAIL prio_second got %b required 10000", grant);
      else n_pass++;
      step(4, '0, '0);
      step(4, '0, 5'b10000);
      step(-1, '0, '0);
      n_chk++;
      if ({grant, busy} !== 6'b0) $display("FAIL prio_done got %b/%b required 0/0", grant, busy);
      else n_pass++;
   endtask

   task automatic test_requeue();
      step(-1, 5'b00001, '0);
      step(-1, '0, '0);
      n_chk++;
      if (grant !== 5'b00001) $display("FAIL rq_grant got %b required 00001", grant);
      else n_pass++;
      step(0, 5'b01000, '0);
      step(0, 5'b01000, '0);
      step(0, 5'b00001, 5'b00001);
      n_chk++;
      if (grant !== 5'b0) $display("FAIL rq_release got %b required 0", grant);
      else n_pass++;
      step(-1, '0, '0);
      n_chk++;
      if (grant !== 5'b00001) $display("FAIL rq_regrant got %b required 00001", grant);
      else n_pass++;
      step(0, '0, 5'b00001);
      step(-1, '0, '0);
      n_chk++;
      if (grant !== 5'b01000) $display("FAIL rq_ch3 got %b required 01000", grant);
      else n_pass++;
      step(3, '0, 5'b01000);
      step(-1, '0, '0);
      step(-1, '0, '0);
      n_chk++;
      if (grant !== 5'b0) $display("FAIL rq_once got %b required 0", grant);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      int order [5] = '{3, 4, 0, 1, 2};
      logic [N-1:0] oh;
      req1 = 5'b00100;
      step(-1, '0, '0);
      req1 = '0;
      step(-1, '0, '0);
      n_chk++;
      if (grant1 !== 5'b00100) $display("FAIL rr_setup got %b required 00100", grant1);
      else n_pass++;
      fin1 = 5'b00100;
      step(-1, '0, '0);
      fin1 = '0;
      req1 = 5'b11111;
      step(-1, '0, '0);
      req1 = '0;
      for (int k = 0; k < 5; k++) begin
         oh = 5'b00001 << order[k];
         step(-1, '0, '0);
         n_chk++;
         if (grant1 !== oh)
            $display("FAIL rr_order_%0d got %b required %b", k, grant1, oh);
         else n_pass++;
         fin1 = oh;
         step(-1, '0, '0);
         fin1 = '0;
      end
      step(-1, '0, '0);
      n_chk++;
      if (grant1 !== 5'b0) $display("FAIL rr_done got %b required 0", grant1);
      else n_pass++;
   endtask

`ifdef SPRITE_SCHED_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      step(-1, 5'b00010, '0);
      step(-1, '0, '0);
      n_chk++;
      if (grant !== 5'b00010) $display("FAIL to_grant got %b required 00010", grant);
      else n_pass++;
      n = 0;
      while (grant !== 5'b0 && n < 40) begin
         step(1, '0, '0);
         n++;
      end
      n_chk++;
      if (n !== 16) $display("FAIL to_cycles got %0d required 16", n);
      else n_pass++;
      n_chk++;
      if (terr !== 1'b1) $display("FAIL to_flag got %b required 1", terr);
      else n_pass++;
      step(-1, 5'b00100, '0);
      step(-1, '0, '0);
      n_chk++;
      if (grant !== 5'b00100) $display("FAIL to_next got %b required 00100", grant);
      else n_pass++;
      step(2, '0, 5'b00100);
      step(-1, '0, '0);
      n_chk++;
      if (terr !== 1'b1) $display("FAIL to_sticky got %b required 1", terr);
      else n_pass++;
   endtask
`else
   task automatic test_timeout();
      n_chk++;
      if ({terr, terr1} !== 2'b00)
         $display("FAIL to_tied got %b required 00", {terr, terr1});
      else n_pass++;
   endtask
`endif

   task automatic test_reset_mid();
      step(-1, 5'b01000, '0);
      step(-1, '0, '0);
      step(3, '0, '0);
      n_chk++;
      if ({grant, plot} !== {5'b01000, 1'b1})
         $display("FAIL rst_pre got %b/%b required 01000/1", grant, plot);
      else n_pass++;
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      n_chk++;
      if ({grant, plot, busy, cur_ch, x, terr} !== '0)
         $display("FAIL rst_async got %h required 0",
                  {grant, plot, busy, cur_ch, x, terr});
      else n_pass++;
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      step(-1, '0, '0);
      step(-1, '0, '0);
      n_chk++;
      if ({grant, busy} !== 6'b0)
         $display("FAIL rst_pending got %b/%b required 0/0", grant, busy);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_priority();
      test_requeue();
      test_round_robin();
      test_timeout();
      test_reset_mid();
      step(-1, '0, '0);
      n_chk++;
      if (exp_q.size() != 0)
         $display("FAIL scoreboard_drain got %0d required 0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got hang required finish");
      $fatal(1, "bench watchdog expired");
   end

endmodule
